// File: rtl/zeroheti_apb_bridge.sv
// OBI subordinate to APB4 manager bridge with NumSel decoded select lines.
// Optional ACCESS-phase timeout enabled by defining ZEROHETI_APB_TIMEOUT_EN.
module zeroheti_apb_bridge #(
  parameter int unsigned          AddrWidth     = 32,
  parameter int unsigned          DataWidth     = 32,
  parameter int unsigned          NumSel        = 4,
  parameter logic [AddrWidth-1:0] BaseAddr      = 32'h0003_0000,
  parameter int unsigned          RegionBits    = 12,
  parameter int unsigned          TimeoutCycles = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        obi_req_i,
  output logic                        obi_gnt_o,
  input  logic [AddrWidth-1:0]        obi_addr_i,
  input  logic                        obi_we_i,
  input  logic [DataWidth/8-1:0]      obi_be_i,
  input  logic [DataWidth-1:0]        obi_wdata_i,
  output logic                        obi_rvalid_o,
  output logic [DataWidth-1:0]        obi_rdata_o,
  output logic                        obi_err_o,
  output logic [AddrWidth-1:0]        paddr_o,
  output logic [NumSel-1:0]           psel_o,
  output logic                        penable_o,
  output logic                        pwrite_o,
  output logic [DataWidth-1:0]        pwdata_o,
  output logic [DataWidth/8-1:0]      pstrb_o,
  output logic [2:0]                  pprot_o,
  input  logic [NumSel*DataWidth-1:0] prdata_i,
  input  logic [NumSel-1:0]           pready_i,
  input  logic [NumSel-1:0]           pslverr_i,
  output logic                        busy_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned IdxWidth  = (NumSel > 1) ? $clog2(NumSel) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e state_q, state_d;

  logic [AddrWidth-1:0] addr_q;
  logic                 we_q;
  logic [StrbWidth-1:0] be_q;
  logic [DataWidth-1:0] wdata_q;
  logic [IdxWidth-1:0]  idx_q;
  logic [DataWidth-1:0] rdata_q;
  logic                 err_q;

  logic [AddrWidth-1:0] dec_off;
  logic [AddrWidth-1:0] dec_region;
  logic                 dec_hit;
  logic [IdxWidth-1:0]  dec_idx;

  logic [DataWidth-1:0] sel_rdata;
  logic                 sel_ready;
  logic                 sel_err;
  logic [NumSel-1:0]    sel_onehot;

  logic                 grant;
  logic                 abort;

  // Lower bound is checked separately so addresses below the window never alias after the subtraction wraps.
  assign dec_off    = obi_addr_i - BaseAddr;
  assign dec_region = dec_off >> RegionBits;
  assign dec_hit    = (obi_addr_i >= BaseAddr) && (dec_region < AddrWidth'(NumSel));
  assign dec_idx    = dec_region[IdxWidth-1:0];

  assign grant = (state_q == IDLE) && obi_req_i;

  always_comb begin
    sel_rdata  = '0;
    sel_ready  = 1'b0;
    sel_err    = 1'b0;
    sel_onehot = '0;
    for (int unsigned k = 0; k < NumSel; k++) begin
      if (idx_q == IdxWidth'(k)) begin
        sel_rdata     = prdata_i[k*DataWidth +: DataWidth];
        sel_ready     = pready_i[k];
        sel_err       = pslverr_i[k];
        sel_onehot[k] = 1'b1;
      end
    end
  end

`ifdef ZEROHETI_APB_TIMEOUT_EN
  localparam logic [15:0] TmoLast = 16'(TimeoutCycles - 1);

  logic [15:0] tmo_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ACCESS && !sel_ready) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end

  assign abort = (state_q == ACCESS) && !sel_ready && (tmo_cnt_q == TmoLast);
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (obi_req_i) state_d = dec_hit ? SETUP : RESP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (sel_ready || abort) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A miss preloads the error response; a completed or aborted ACCESS overwrites it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (grant) begin
      addr_q  <= obi_addr_i;
      we_q    <= obi_we_i;
      be_q    <= obi_be_i;
      wdata_q <= obi_wdata_i;
      idx_q   <= dec_hit ? dec_idx : '0;
      rdata_q <= '0;
      err_q   <= !dec_hit;
    end else if (state_q == ACCESS && sel_ready) begin
      rdata_q <= sel_rdata;
      err_q   <= sel_err;
    end else if (abort) begin
      rdata_q <= '0;
      err_q   <= 1'b1;
    end
  end

  assign obi_gnt_o    = grant;
  assign obi_rvalid_o = (state_q == RESP);
  assign obi_rdata_o  = obi_rvalid_o ? rdata_q : '0;
  assign obi_err_o    = obi_rvalid_o & err_q;

  assign psel_o    = (state_q == SETUP || state_q == ACCESS) ? sel_onehot : '0;
  assign penable_o = (state_q == ACCESS);
  assign paddr_o   = addr_q;
  assign pwrite_o  = we_q;
  assign pwdata_o  = wdata_q;
  assign pstrb_o   = we_q ? be_q : '0;
  assign pprot_o   = 3'b000;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_zeroheti_apb_bridge.sv
// Directed self-checking bench for zeroheti_apb_bridge with a small APB peripheral model.
// Covers the ZEROHETI_APB_TIMEOUT_EN build as well as the default build.
module tb_zeroheti_apb_bridge;

  logic         clk;
  logic         rst_n;
  logic         obi_req;
  logic         obi_gnt;
  logic [31:0]  obi_addr;
  logic         obi_we;
  logic [3:0]   obi_be;
  logic [31:0]  obi_wdata;
  logic         obi_rvalid;
  logic [31:0]  obi_rdata;
  logic         obi_err;
  logic [31:0]  paddr;
  logic [3:0]   psel;
  logic         penable;
  logic         pwrite;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [2:0]   pprot;
  logic [127:0] prdata;
  logic [3:0]   pready;
  logic [3:0]   pslverr;
  logic         busy;

  int          tests;
  int          failures;
  int          wait_cfg [4];
  logic [3:0]  stray;
  int          acc_cnt;
  logic [31:0] cur_addr;
  logic        cur_we;
  logic [3:0]  cur_be;
  logic [31:0] cur_wdata;

  zeroheti_apb_bridge #(.TimeoutCycles(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .obi_req_i(obi_req), .obi_gnt_o(obi_gnt), .obi_addr_i(obi_addr),
    .obi_we_i(obi_we), .obi_be_i(obi_be), .obi_wdata_i(obi_wdata),
    .obi_rvalid_o(obi_rvalid), .obi_rdata_o(obi_rdata), .obi_err_o(obi_err),
    .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .pwdata_o(pwdata), .pstrb_o(pstrb), .pprot_o(pprot),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr), .busy_o(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Peripheral model: wait_cfg 0 means ready is tied high even when not selected.
  always @(posedge clk) begin
    if (penable) acc_cnt <= acc_cnt + 1;
    else         acc_cnt <= 0;
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      pready[k] = stray[k] | (wait_cfg[k] == 0) |
                  (psel[k] & penable & (acc_cnt >= wait_cfg[k]));
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [3:0] be,
                               input logic [31:0] wdata, output int gnt_wait);
    cur_addr  = addr;
    cur_we    = we;
    cur_be    = be;
    cur_wdata = wdata;
    obi_req   = 1'b1;
    obi_addr  = addr;
    obi_we    = we;
    obi_be    = be;
    obi_wdata = wdata;
    gnt_wait  = 0;
    #1;
    while (!obi_gnt && gnt_wait < 50) begin
      @(negedge clk);
      #1;
      gnt_wait++;
    end
    checkOutput("gnt", {31'b0, obi_gnt}, 32'd1);
    @(posedge clk);
    #1;
    obi_req = 1'b0;
  endtask

  task automatic waitResponse(input logic [3:0] exp_psel, output int lat, output int acc,
                              output logic [31:0] rdata, output logic err);
    lat = 0;
    acc = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      lat = c;
      if (obi_rvalid) break;
      checkOutput("psel", {28'b0, psel}, {28'b0, exp_psel});
      checkOutput("penable", {31'b0, penable}, (c >= 2) ? 32'd1 : 32'd0);
      checkOutput("paddr", paddr, cur_addr);
      checkOutput("pwrite", {31'b0, pwrite}, {31'b0, cur_we});
      checkOutput("pstrb", {28'b0, pstrb}, cur_we ? {28'b0, cur_be} : 32'd0);
      if (cur_we) checkOutput("pwdata", pwdata, cur_wdata);
      if (penable) acc++;
    end
    checkOutput("rvalid", {31'b0, obi_rvalid}, 32'd1);
    rdata = obi_rdata;
    err   = obi_err;
    checkOutput("resp_psel", {28'b0, psel}, 32'd0);
    checkOutput("resp_penable", {31'b0, penable}, 32'd0);
  endtask

  initial begin
    int          gw;
    int          lat;
    int          acc;
    int          busy_cycles;
    logic [31:0] rd;
    logic        er;

    tests     = 0;
    failures  = 0;
    rst_n     = 1'b0;
    obi_req   = 1'b0;
    obi_addr  = '0;
    obi_we    = 1'b0;
    obi_be    = '0;
    obi_wdata = '0;
    stray     = '0;
    acc_cnt   = 0;
    pslverr   = '0;
    wait_cfg[0] = 3;
    wait_cfg[1] = 0;
    wait_cfg[2] = 0;
    wait_cfg[3] = 100000;
    prdata = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_0000};

    #3;
    checkOutput("rst_psel", {28'b0, psel}, 32'd0);
    checkOutput("rst_penable", {31'b0, penable}, 32'd0);
    checkOutput("rst_rvalid", {31'b0, obi_rvalid}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_paddr", paddr, 32'd0);
    checkOutput("rst_pstrb", {28'b0, pstrb}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Read hit, zero wait
    applyStimulus(32'h0003_1004, 1'b0, 4'hF, 32'h0, gw);
    waitResponse(4'b0010, lat, acc, rd, er);
    checkOutput("rd_lat", lat, 3);
    checkOutput("rd_acc", acc, 1);
    checkOutput("rd_data", rd, 32'hDEAD_BEEF);
    checkOutput("rd_err", {31'b0, er}, 32'd0);
    @(negedge clk);

    // Write with three wait states
    applyStimulus(32'h0003_0008, 1'b1, 4'b0101, 32'h1234_5678, gw);
    waitResponse(4'b0001, lat, acc, rd, er);
    checkOutput("wr_lat", lat, 6);
    checkOutput("wr_acc", acc, 4);
    checkOutput("wr_err", {31'b0, er}, 32'd0);
    @(negedge clk);

    // Slave error, then back-to-back request granted the cycle after RESP
    pslverr = 4'b0100;
    applyStimulus(32'h0003_2000, 1'b0, 4'hF, 32'h0, gw);
    waitResponse(4'b0100, lat, acc, rd, er);
    checkOutput("slverr_lat", lat, 3);
    checkOutput("slverr_err", {31'b0, er}, 32'd1);
    checkOutput("slverr_data", rd, 32'h2222_2222);
    pslverr = '0;
    applyStimulus(32'h0003_1000, 1'b0, 4'hF, 32'h0, gw);
    checkOutput("gnt_after_resp", gw, 1);
    waitResponse(4'b0010, lat, acc, rd, er);
    checkOutput("b2b_lat", lat, 3);
    checkOutput("b2b_data", rd, 32'hDEAD_BEEF);
    checkOutput("b2b_err", {31'b0, er}, 32'd0);
    @(negedge clk);

    // Decode misses above and below the window
    applyStimulus(32'h0003_4000, 1'b0, 4'hF, 32'h0, gw);
    waitResponse(4'b0000, lat, acc, rd, er);
    checkOutput("miss_hi_lat", lat, 1);
    checkOutput("miss_hi_err", {31'b0, er}, 32'd1);
    checkOutput("miss_hi_data", rd, 32'd0);
    @(negedge clk);
    applyStimulus(32'h0002_FFFC, 1'b1, 4'hF, 32'hFFFF_FFFF, gw);
    waitResponse(4'b0000, lat, acc, rd, er);
    checkOutput("miss_lo_lat", lat, 1);
    checkOutput("miss_lo_err", {31'b0, er}, 32'd1);
    checkOutput("miss_lo_data", rd, 32'd0);
    @(negedge clk);

`ifdef ZEROHETI_APB_TIMEOUT_EN
    // Hung peripheral aborts after 8 ACCESS cycles; a late ready is ignored
    applyStimulus(32'h0003_3000, 1'b0, 4'hF, 32'h0, gw);
    waitResponse(4'b1000, lat, acc, rd, er);
    checkOutput("tmo_lat", lat, 10);
    checkOutput("tmo_acc", acc, 8);
    checkOutput("tmo_err", {31'b0, er}, 32'd1);
    checkOutput("tmo_data", rd, 32'd0);
    stray = 4'b1000;
    busy_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (obi_rvalid || busy || psel != 4'b0000) busy_cycles++;
    end
    checkOutput("tmo_stray", busy_cycles, 0);
    stray = '0;
    @(negedge clk);
    applyStimulus(32'h0003_3000, 1'b0, 4'hF, 32'h0, gw);
    repeat (3) @(negedge clk);
`else
    // Without the timeout a hung peripheral keeps the bridge busy
    applyStimulus(32'h0003_3000, 1'b0, 4'hF, 32'h0, gw);
    busy_cycles = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy && !obi_rvalid) busy_cycles++;
    end
    checkOutput("hang_busy", busy_cycles, 1000);
`endif

    // Asynchronous reset while stuck in ACCESS
    checkOutput("pre_rst_psel", {28'b0, psel}, 32'h8);
    checkOutput("pre_rst_penable", {31'b0, penable}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_psel", {28'b0, psel}, 32'd0);
    checkOutput("arst_penable", {31'b0, penable}, 32'd0);
    checkOutput("arst_rvalid", {31'b0, obi_rvalid}, 32'd0);
    checkOutput("arst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_rvalid", {31'b0, obi_rvalid}, 32'd0);
    applyStimulus(32'h0003_1004, 1'b0, 4'hF, 32'h0, gw);
    waitResponse(4'b0010, lat, acc, rd, er);
    checkOutput("post_rst_lat", lat, 3);
    checkOutput("post_rst_data", rd, 32'hDEAD_BEEF);
    checkOutput("post_rst_err", {31'b0, er}, 32'd0);
    checkOutput("pprot", {29'b0, pprot}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
